// File: rtl/branch_ctrl_if.sv
// Bundle between the main control unit / ALU side and the branch sequencer.
`default_nettype none

interface branch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             br_req;
    logic [1:0]       br_type;
    logic             br_flush;
    logic             flag_in;
    logic             cnt_clr;
    logic [2:0]       alu_sel;
    logic [1:0]       alu_flag;
    logic             br_busy;
    logic             pc_write;
    logic             br_done;
    logic             br_taken;
    logic [CNT_W-1:0] taken_cnt;

    modport slave (
        input  br_req, br_type, br_flush, flag_in, cnt_clr,
        output alu_sel, alu_flag, br_busy, pc_write, br_done, br_taken, taken_cnt
    );

    modport master (
        output br_req, br_type, br_flush, flag_in, cnt_clr,
        input  alu_sel, alu_flag, br_busy, pc_write, br_done, br_taken, taken_cnt
    );
endinterface

`default_nettype wire

// File: rtl/branch_ctrl.sv
// Multicycle branch sequencer: drives ALU op / flag select, samples the flag,
// commits with a one-cycle PC-write pulse and counts taken branches.
`default_nettype none

module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    branch_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_EVAL   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       w_alu_sel;
    logic [1:0]       w_alu_flag;
    logic             w_busy;
    logic             w_commit;
    logic             w_done;
    logic             w_pc_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            type_q  <= 2'b00;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        taken_d    = taken_q;
        w_alu_sel  = 3'b000;
        w_alu_flag = 2'b00;
        w_busy     = 1'b0;
        w_commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.br_req && !bus.br_flush) begin
                    type_d  = bus.br_type;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                taken_d = bus.flag_in;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Decode is a function of the latched type only, so it holds across the whole branch.
        if (state_q != S_IDLE) begin
            w_busy     = 1'b1;
            w_alu_sel  = type_q[1] ? 3'b010 : 3'b111;
            w_alu_flag = type_q;
        end
        if (bus.br_flush) begin
            state_d = S_IDLE;
        end
    end

    assign w_done     = w_commit & ~bus.br_flush;
    assign w_pc_write = w_done & taken_q;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (w_pc_write && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign bus.alu_sel   = w_alu_sel;
    assign bus.alu_flag  = w_alu_flag;
    assign bus.br_busy   = w_busy;
    assign bus.br_done   = w_done;
    assign bus.pc_write  = w_pc_write;
    assign bus.br_taken  = w_pc_write;
    assign bus.taken_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/branch_ctrl.md
# branch_ctrl

Multicycle branch sequencer for the processor datapath. On a branch request it drives the ALU operation and the 2-bit branch-flag select of the flag multiplexer, gives the ALU one settle cycle, samples the selected flag, and commits the branch with a single-cycle PC-write pulse. It also counts committed taken branches. It sits between the main control unit, which issues requests, and the ALU, flag mux and PC register.

## Interface
- CNT_W, 16, width of the taken-branch counter

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- br_req  in  1  branch request; sampled only in IDLE
- br_type  in  2  00 ble, 01 bgt, 10 beq, 11 bne; sampled with br_req
- br_flush  in  1  synchronous abort; returns the FSM to IDLE
- flag_in  in  1  selected flag returned from the flag mux
- cnt_clr  in  1  synchronous clear of taken_cnt
- alu_sel  out  3  ALU operation: 000 idle/pass, 010 subtract, 111 compare
- alu_flag  out  2  flag-mux select: 00 OR (lt|eq), 01 gt, 10 zero, 11 not-zero
- br_busy  out  1  high in SETUP, EVAL and COMMIT
- pc_write  out  1  one-cycle pulse when a branch commits taken
- br_done  out  1  one-cycle pulse when any branch commits
- br_taken  out  1  branch outcome; valid only while br_done=1
- taken_cnt  out  CNT_W  saturating count of committed taken branches

## Operation
- States: IDLE, SETUP, EVAL, COMMIT. Encoding is free.
- IDLE: if br_req=1, latch br_type into type_q and go to SETUP. Otherwise stay in IDLE.
- SETUP goes to EVAL unconditionally.
- EVAL: latch flag_in into taken_q and go to COMMIT.
- COMMIT goes to IDLE unconditionally.
- Decode of type_q, held constant in SETUP, EVAL and COMMIT:
  - ble: alu_sel=111, alu_flag=00
  - bgt: alu_sel=111, alu_flag=01
  - beq: alu_sel=010, alu_flag=10
  - bne: alu_sel=010, alu_flag=11
- In IDLE, alu_sel=000 and alu_flag=00.
- Output equations:
  - pc_write = (state==COMMIT) & taken_q & ~br_flush
  - br_done = (state==COMMIT) & ~br_flush
  - br_taken = br_done & taken_q
- br_flush=1 in any state forces next state IDLE and suppresses pc_write and br_done. If br_flush and br_req are both high in IDLE, the request is dropped. br_flush has priority over everything except reset.
- br_req is ignored while br_busy=1. No queueing; the requester holds br_req or re-issues it.
- taken_cnt:
  - Increments by 1 on each edge where pc_write=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces it to 0 and wins over a simultaneous increment.
- br_type and flag_in are don't-care outside their sampling points.

## Timing
- Reset, asynchronous and active-low, forces:
  - state = IDLE, type_q = 00, taken_q = 0, taken_cnt = 0
  - outputs: alu_sel=000, alu_flag=00, br_busy=0, pc_write=0, br_done=0, br_taken=0
- Reset deasserting mid-branch leaves the FSM in IDLE; the interrupted branch is lost and no pulse is emitted.
- Latency: br_req is sampled at edge E0. The ALU controls are valid from E0 to E3. flag_in is sampled at E2. br_done and pc_write are high between E2 and E3.
- Throughput: one branch per 4 cycles. The earliest next acceptance is at E4; br_req at E3 is ignored because COMMIT is still busy.
- flag_in must be stable at E2. The ALU and flag mux have two full cycles of settle time, E0 to E2.
- br_busy is a pure state decode with no combinational path from inputs. pc_write, br_done and br_taken depend combinationally on br_flush only.

## Test plan
- Reset: hold reset=0 with br_req=1 → all outputs 0 and taken_cnt=0. Release and idle 3 cycles → still IDLE, no pulses.
- beq taken: br_type=10, br_req for one cycle, flag_in=1 at E2 → alu_sel=010 and alu_flag=10 over E0–E3; pc_write=br_done=br_taken=1 for exactly one cycle after E2; taken_cnt=1.
- ble not taken, then bgt taken:
  - ble with flag_in=0 → alu_sel=111, alu_flag=00, br_done=1, pc_write=0, br_taken=0.
  - br_req held high throughout → second request accepted at E4, not E3.
  - bgt with flag_in=1 → alu_flag=01, pc_write pulses.
- Flush: br_flush=1 during COMMIT of a taken bne → no pc_write, no br_done, taken_cnt unchanged, IDLE next. Repeat with flush during SETUP → same result.
- Counter, with CNT_W=4: 16 taken branches → taken_cnt saturates at 15. cnt_clr asserted on the same edge as a pc_write → taken_cnt=0.
- Asynchronous reset mid-EVAL: pull reset low between edges → outputs clear immediately; no pc_write after release.
